// File: rtl/piso_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_serializer: parallel-in serial-out shifter, per-word MSB/LSB order.  |
// | Optional even-parity trailer bit when PISO_PARITY_EN is defined.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int c_FRAME_LEN = WIDTH + 1;
`else
  localparam int c_FRAME_LEN = WIDTH;
`endif
  localparam int c_CNT_W = $clog2(c_FRAME_LEN);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_sreg, w_sreg_n;
  logic               r_dir, w_dir_n;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_n;
  logic               r_sout, r_valid, r_done;
  logic               w_sout_n, w_valid_n, w_done_n, w_bit_n, w_accept;
`ifdef PISO_PARITY_EN
  logic               r_par, w_par_n;
`endif

  assign ready    = (r_state == S_IDLE) || (r_cnt == '0);
  assign w_accept = load && ready;

  always_comb begin
    w_state_n = r_state;
    w_sreg_n  = r_sreg;
    w_dir_n   = r_dir;
    w_cnt_n   = r_cnt;
`ifdef PISO_PARITY_EN
    w_par_n   = r_par;
`endif
    if (w_accept) begin
      w_state_n = S_SHIFT;
      w_sreg_n  = din;
      w_dir_n   = dir;
      w_cnt_n   = c_CNT_W'(c_FRAME_LEN - 1);
`ifdef PISO_PARITY_EN
      w_par_n   = ^din;
`endif
    end else if (r_state == S_SHIFT) begin
      w_sreg_n = r_dir ? (r_sreg >> 1) : (r_sreg << 1);
      if (r_cnt != '0) begin
        w_cnt_n = r_cnt - c_CNT_W'(1);
      end else begin
        w_state_n = S_IDLE;
      end
    end

    // Outputs are registered, so they are derived from the next-state values.
    w_valid_n = (w_state_n == S_SHIFT);
    w_bit_n   = w_dir_n ? w_sreg_n[0] : w_sreg_n[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (w_cnt_n == '0) begin
      w_bit_n = w_par_n;
    end
`endif
    w_sout_n = w_valid_n && w_bit_n;
    w_done_n = w_valid_n && (w_cnt_n == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_sreg  <= w_sreg_n;
      r_dir   <= w_dir_n;
      r_cnt   <= w_cnt_n;
      r_sout  <= w_sout_n;
      r_valid <= w_valid_n;
      r_done  <= w_done_n;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Directed-vector bench for piso_serializer (WIDTH=8), both frame-length builds.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dir = 1'b0;
  logic       ready, sout, sout_valid, done;

  int n_vec = 0;
  int n_bad = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .dir(dir),
    .ready(ready), .sout(sout), .sout_valid(sout_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       ld;
    logic [7:0] d;
    logic       dr;
    logic       e_ready;
    logic       e_sout;
    logic       e_valid;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic l, logic [7:0] d, logic dr,
                              logic er, logic es, logic ev, logic ed);
    vec_t v;
    v.rst_n = r; v.ld = l; v.d = d; v.dr = dr;
    v.e_ready = er; v.e_sout = es; v.e_valid = ev; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle();
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // busy_k: vector index that pulses a stray load; abort_k: vector that asserts reset.
  function automatic void add_frame(logic [7:0] word, logic d, int busy_k, int abort_k);
    logic b;
    for (int k = 0; k < FL; k++) begin
      if (k == abort_k) begin
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k < 8) b = d ? word[k] : word[7-k];
      else       b = ^word;
      add(1'b1, (k == 0) || (k == busy_k), (k == 0) ? word : 8'h7E,
          (k == 0) ? d : ~d, k == FL-1, b, 1'b1, k == FL-1);
    end
  endfunction

  task automatic step(logic r, logic l, logic [7:0] d, logic dr);
    rst = r; load = l; din = d; dir = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int idx, logic act, logic exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    int vcount, ones, ndone, d1, d2;
    bit seen_done;

    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_idle();
    add_frame(8'hB4, 1'b0, 99, 99); add_idle();
    add_frame(8'hB4, 1'b1, 99, 99); add_idle();
    add_frame(8'hFF, 1'b0, 99, 99);
    add_frame(8'h00, 1'b0, 99, 99); add_idle();
    add_frame(8'h81, 1'b0, 3, 99);  add_idle();
    add_frame(8'hA5, 1'b0, 99, 4);  add_idle();
    add(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_idle();
    add_frame(8'h3C, 1'b1, 99, 99); add_idle();

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].ld, vecs[i].d, vecs[i].dr);
      n_vec++;
      chk("ready", i, ready, vecs[i].e_ready);
      chk("sout", i, sout, vecs[i].e_sout);
      chk("sout_valid", i, sout_valid, vecs[i].e_valid);
      chk("done", i, done, vecs[i].e_done);
    end

    // Back-to-back: second load issued only once done is observed.
    vcount = 0; ones = 0; ndone = 0; d1 = -1; d2 = -1; seen_done = 0;
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int c = 0; c < 2*FL + 4; c++) begin
      if (sout_valid) begin
        vcount++;
        if (sout) ones++;
      end
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (done && !seen_done) begin
        seen_done = 1;
        step(1'b1, 1'b1, 8'h00, 1'b0);
      end else begin
        step(1'b1, 1'b0, 8'h00, 1'b0);
      end
    end
    n_vec++;
    chk("b2b_first_done", 0, d1 == FL-1, 1'b1);
    chk("b2b_valid_cycles", vcount, vcount == 2*FL, 1'b1);
    chk("b2b_ones", ones, ones == 8, 1'b1);
    chk("b2b_done_pulses", ndone, ndone == 2, 1'b1);
    chk("b2b_done_gap", d2 - d1, (d2 - d1) == FL, 1'b1);

`ifdef PISO_PARITY_EN
    step(1'b1, 1'b1, 8'hB4, 1'b0);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
    n_vec++;
    chk("par_b4_pre_done", 0, done, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_b4_bit", 0, sout, 1'b0);
    chk("par_b4_done", 0, done, 1'b1);
    chk("par_b4_valid", 0, sout_valid, 1'b1);
    step(1'b1, 1'b1, 8'h07, 1'b1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
    n_vec++;
    chk("par_07_pre_done", 0, done, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_07_bit", 0, sout, 1'b1);
    chk("par_07_done", 0, done, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_07_idle", 0, sout_valid, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register: accepts a WIDTH-bit word on a load handshake and drives it out one bit per clock. Frames are MSB-first or LSB-first, and the order is chosen per word. It is the transmit-side counterpart to the team's bidirectional serial-in/parallel-out shift register. Its `sout`/`sout_valid` pair feeds that register's serial input directly.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2 to 32.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-low; when `rst`==0 at a rising edge, all state returns to reset values.
- `load`  input  1  request to start a frame with `din`.
- `din`  input  WIDTH  parallel word; sampled only when a load is accepted.
- `dir`  input  1  bit order; sampled with `din`. 0 = MSB first, 1 = LSB first.
- `ready`  output  1  block can accept `load` this cycle.
- `sout`  output  1  serial data bit.
- `sout_valid`  output  1  `sout` carries a frame bit this cycle.
- `done`  output  1  single-cycle pulse coincident with the last bit of a frame.

## Operation
- State machine, two states:
  - IDLE: `ready`=1, `sout_valid`=0.
  - SHIFT: serial output in progress.
- Load acceptance: load is accepted at a rising edge when `load`=1 and `ready`=1. On acceptance:
  - `din` is captured into the shift register and `dir` into an order latch.
  - The bit counter is set to FRAME_LEN-1. FRAME_LEN = WIDTH, or WIDTH+1 with parity enabled.
  - State goes to SHIFT.
- In SHIFT, each cycle:
  - `sout` = current bit: the register MSB when dir=0, the register LSB when dir=1.
  - `sout_valid`=1.
  - At the edge, the register shifts toward the output end, filling with 0, and the counter decrements.
- Last bit is when counter==0. In that cycle:
  - `done`=1 and `ready`=1.
  - If `load`=1 at that edge, the new word is captured and SHIFT continues with no gap.
  - Otherwise the state returns to IDLE.
- `load` while `ready`=0 is ignored. No error flag is raised, and in-flight data and order are unaffected.
- `din` and `dir` changes outside an accepting edge have no effect.
- When `sout_valid`=0, `sout` is driven 0.
- Reset mid-frame: the frame is abandoned immediately. No `done` is generated and the next cycle shows reset values.

## Timing
- Reset values: `ready`=1, `sout`=0, `sout_valid`=0, `done`=0, state IDLE, counter 0, shift register 0.
- Latency: for a load accepted at edge N, the first bit appears on `sout` in the cycle after edge N.
- The frame occupies FRAME_LEN consecutive cycles with `sout_valid`=1.
- `done` is high in the final of those cycles only.
- Throughput: one frame per FRAME_LEN cycles with back-to-back loads; `sout_valid` stays continuously high.
- `ready` is combinational from state and counter: IDLE, or SHIFT with counter==0.
- All other outputs are registered.
- Simultaneous `rst`=0 and `load`=1: reset wins and the load is dropped.

## Configuration
- Macro: `PISO_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is captured at load.
  - It is sent as bit WIDTH+1 after the data, regardless of `dir`.
  - FRAME_LEN = WIDTH+1, and `done` coincides with the parity bit.
- Undefined:
  - No parity logic is present and FRAME_LEN = WIDTH.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles, then release → `ready`=1, `sout_valid`=0, `done`=0, `sout`=0.
- MSB-first frame: load `din`=8'hB4, `dir`=0 → `sout` = 1,0,1,1,0,1,0,0 over 8 cycles starting the cycle after load; `sout_valid` high for exactly 8 cycles; `done` on the 8th only.
- LSB-first frame: load 8'hB4 with `dir`=1 → `sout` = 0,0,1,0,1,1,0,1.
- Back-to-back loads:
  - Stimulus: load 8'hFF, then assert `load` with 8'h00 during the `done` cycle.
  - Response: 16 consecutive valid cycles, 8 ones followed by 8 zeros; two `done` pulses 8 cycles apart.
- Load while busy:
  - Stimulus: load 8'h81, dir=0. Pulse `load` with 8'h7E in cycle 3 of the frame.
  - Response: output stays 1,0,0,0,0,0,0,1 and the 8'h7E word is never sent.
- Reset mid-frame:
  - Stimulus: assert `rst`=0 on frame cycle 4.
  - Response: next cycle `sout_valid`=0 and `ready`=1, with no `done` pulse.
- Parity check, with `PISO_PARITY_EN` defined:
  - 8'hB4 → 9th bit 0.
  - 8'h07 → 9th bit 1.
  - In both cases `done` lands on the 9th cycle.
